fb_access_arbiter: RTL and testbench
====================================

Name: fb_access_arbiter

Overview:
- Shares the single-port 320x240 12-bit frame buffer RAM between three users:
  - the display read path (the frame scaler),
  - a pixel-write requester (CPU/GPU) with a valid/ready handshake,
  - an internal clear-screen fill engine.
- The display path has absolute priority.
- Fill and write traffic use only the cycles the display does not need.
- Sits between the frame buffer RAM and its clients in the display subsystem.

Parameters:
- ADDR_WIDTH, 17, frame buffer address width (`DISP_ADDR_WIDTH`).
- DATA_WIDTH, 12, pixel width (4:4:4 RGB).
- FB_DEPTH, 76800, number of valid pixel locations (320*240).

Ports:
- clk  in  1  system/pixel clock
- reset_n  in  1  asynchronous active-low reset
- disp_req  in  1  display needs a RAM read this cycle (in_display_area)
- disp_addr  in  ADDR_WIDTH  display read address
- disp_rdata  out  DATA_WIDTH  read data; valid 1 cycle after disp_req
- wr_valid  in  1  writer has a pixel
- wr_ready  out  1  write accepted this cycle
- wr_addr  in  ADDR_WIDTH  writer address
- wr_data  in  DATA_WIDTH  writer pixel
- fill_start  in  1  one-cycle pulse, start clear-screen
- fill_color  in  DATA_WIDTH  fill colour, sampled on accepted fill_start
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse when the last fill pixel is written
- wr_drop  out  1  one-cycle pulse: accepted write had address >= FB_DEPTH
- stall_count  out  16  writer stall counter (see Optional Feature)
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data (synchronous, 1-cycle latency)

Behaviour:
- RAM port muxing is combinational; the grant is decided each cycle with priority disp_req > FILL > writer.
- disp_req=1:
  - mem_addr=disp_addr, mem_we=0, wr_ready=0.
  - The fill counter does not advance.
- disp_rdata = mem_rdata (pass-through; 1-cycle latency is set by the RAM).
- FSM states:
  - IDLE: fill_start -> FILL. Latch fill_color; clear fill_cnt to 0.
  - FILL: on each non-display cycle, write fill_color at fill_cnt, then increment fill_cnt.
    - After the write at FB_DEPTH-1: -> DONE.
  - DONE: fill_done=1 for exactly one cycle -> IDLE.
- fill_busy=1 in FILL and DONE.
- fill_start in FILL or DONE is ignored; no restart, no colour change.
- wr_ready = !disp_req && state==IDLE.
- Handshake: a write transfers when wr_valid && wr_ready.
  - Transfer with wr_addr < FB_DEPTH: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - Transfer with wr_addr >= FB_DEPTH: handshake completes, mem_we=0, wr_drop pulses the next cycle (registered).
- A writer request is never lost: wr_valid is held by the requester until wr_ready.
- fill_start and wr_valid in the same IDLE cycle:
  - The write is accepted that cycle (wr_ready is already 1).
  - FILL begins the next cycle, so a fill always overwrites a coincident write.
- Idle cycles (no grant): mem_we=0, mem_addr=0.
- fill_cnt is ADDR_WIDTH bits and compares against FB_DEPTH-1; it never wraps.
- Reset (asynchronous, any time including mid-fill):
  - state=IDLE, fill_cnt=0, latched colour=0.
  - fill_busy=0, fill_done=0, wr_drop=0, stall_count=0.
  - Combinational outputs follow the idle mux.

Optional Feature:
- Macro FB_ARB_STATS_EN.
- Defined: stall_count increments every cycle with wr_valid && !wr_ready.
  - Saturates at 16'hFFFF.
  - Cleared by reset and on fill_done.
- Undefined: stall_count is tied to 16'h0000; no counter logic is generated.

Decomposition:
- Shared package/header (alongside memory_sizes.vh):
  - FB_WIDTH=320, FB_HEIGHT=240, FB_DEPTH.
  - Fill FSM state encodings (IDLE, FILL, DONE).
- One natural sub-module, fb_fill_engine: the FSM, fill_cnt and latched colour.
  - Input: slot_free.
  - Outputs: fill_we, fill_addr, fill_data, busy, done.
- The arbiter top holds the priority mux, the writer handshake and the stats counter.

Test Plan:
- Reset, no requests -> wr_ready=1, mem_we=0, fill_busy=0, stall_count=0.
- disp_req=1 with disp_addr=17'd500; RAM holds 12'hABC at 500 -> mem_addr=500, mem_we=0, disp_rdata=12'hABC next cycle. A concurrent wr_valid sees wr_ready=0 and is held.
- disp_req=0; wr_valid with wr_addr=1234, wr_data=12'h0F0 -> same cycle wr_ready=1, mem_we=1, mem_addr=1234, mem_wdata=12'h0F0.
- fill_start with fill_color=12'h000, disp_req toggling 50% -> exactly 76800 writes at addresses 0..76799, no display cycle ever writes, one fill_done pulse, wr_ready=0 throughout the fill.
- wr_addr=76800, wr_valid=1 -> handshake completes, mem_we=0, wr_drop=1 on the following cycle.
- Assert reset_n low at fill_cnt=1000 -> immediately fill_busy=0; after release, a new fill restarts at address 0. With FB_ARB_STATS_EN defined, 10 stalled write cycles -> stall_count=10.

Source files
------------

// File: rtl/fb_access_arbiter_pkg.sv
// Shared frame buffer geometry and fill-engine state encoding for the
// frame buffer access arbiter.
package fb_access_arbiter_pkg;

  localparam int FB_WIDTH        = 320;
  localparam int FB_HEIGHT       = 240;
  localparam int FB_DEPTH        = FB_WIDTH * FB_HEIGHT;
  localparam int DISP_ADDR_WIDTH = 17;
  localparam int PIX_WIDTH       = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/fb_fill_engine.sv
// Clear-screen fill engine: walks every frame buffer location once, writing
// the latched colour only in cycles the display leaves free.
module fb_fill_engine #(
  parameter int ADDR_WIDTH = fb_access_arbiter_pkg::DISP_ADDR_WIDTH,
  parameter int DATA_WIDTH = fb_access_arbiter_pkg::PIX_WIDTH,
  parameter int FB_DEPTH   = fb_access_arbiter_pkg::FB_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] color,
  input  logic                  slot_free,
  output logic                  fill_we,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  busy,
  output logic                  done
);
  import fb_access_arbiter_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_DEPTH - 1);

  fill_state_e           r_state;
  fill_state_e           w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_fill_cnt;
  logic [DATA_WIDTH-1:0] r_color;
  logic                  w_last;

  assign w_last = (r_fill_cnt == LAST_ADDR);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first keeps this combinational and latch-free.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)               w_state_nxt = ST_FILL;
      ST_FILL: if (slot_free && w_last) w_state_nxt = ST_DONE;
      ST_DONE:                          w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  // The counter holds at the last address after the final write; a new start clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fill_cnt <= '0;
      r_color    <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_fill_cnt <= '0;
      r_color    <= color;
    end else if (r_state == ST_FILL && slot_free && !w_last) begin
      r_fill_cnt <= r_fill_cnt + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    fill_we = (r_state == ST_FILL) && slot_free;
    busy    = (r_state != ST_IDLE);
    done    = (r_state == ST_DONE);
  end

  assign fill_addr = r_fill_cnt;
  assign fill_data = r_color;

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port frame buffer arbiter: display > fill engine > pixel writer.
// Optional writer stall statistics are enabled by defining FB_ARB_STATS_EN.
module fb_access_arbiter #(
  parameter int ADDR_WIDTH = fb_access_arbiter_pkg::DISP_ADDR_WIDTH,
  parameter int DATA_WIDTH = fb_access_arbiter_pkg::PIX_WIDTH,
  parameter int FB_DEPTH   = fb_access_arbiter_pkg::FB_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic [DATA_WIDTH-1:0] disp_rdata,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_color,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  wr_drop,
  output logic [15:0]           stall_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  import fb_access_arbiter_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_DEPTH - 1);

  logic                  w_slot_free;
  logic                  w_fill_we;
  logic [ADDR_WIDTH-1:0] w_fill_addr;
  logic [DATA_WIDTH-1:0] w_fill_data;
  logic                  w_fill_busy;
  logic                  w_fill_done;
  logic                  w_wr_xfer;
  logic                  w_wr_in_range;
  logic                  r_wr_drop;

  fb_fill_engine #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .FB_DEPTH   (FB_DEPTH)
  ) u_fill (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (fill_start),
    .color     (fill_color),
    .slot_free (w_slot_free),
    .fill_we   (w_fill_we),
    .fill_addr (w_fill_addr),
    .fill_data (w_fill_data),
    .busy      (w_fill_busy),
    .done      (w_fill_done)
  );

  // The writer is shut out for the whole fill, including the DONE cycle.
  assign w_slot_free   = !disp_req;
  assign wr_ready      = w_slot_free && !w_fill_busy;
  assign w_wr_xfer     = wr_valid && wr_ready;
  assign w_wr_in_range = (wr_addr <= LAST_ADDR);

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (disp_req) begin
      mem_addr = disp_addr;
    end else if (w_fill_we) begin
      mem_addr  = w_fill_addr;
      mem_we    = 1'b1;
      mem_wdata = w_fill_data;
    end else if (w_wr_xfer && w_wr_in_range) begin
      mem_addr  = wr_addr;
      mem_we    = 1'b1;
      mem_wdata = wr_data;
    end
  end

  // Out-of-range writes still complete the handshake; they are reported a cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_wr_drop <= 1'b0;
    else          r_wr_drop <= w_wr_xfer && !w_wr_in_range;
  end

`ifdef FB_ARB_STATS_EN
  logic [15:0] r_stall_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_stall_count <= '0;
    else if (w_fill_done)
      r_stall_count <= '0;
    else if (wr_valid && !wr_ready && r_stall_count != 16'hFFFF)
      r_stall_count <= r_stall_count + 16'd1;
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = 16'h0000;
`endif

  assign disp_rdata = mem_rdata;
  assign fill_busy  = w_fill_busy;
  assign fill_done  = w_fill_done;
  assign wr_drop    = r_wr_drop;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Self-checking bench for fb_access_arbiter: frame buffer RAM model, a
// transaction-level reference model and per-cycle comparison.
module tb_fb_access_arbiter;
  localparam int AW    = 17;
  localparam int DW    = 12;
  localparam int DEPTH = 76800;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_rdata;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          fill_start = 1'b0;
  logic [DW-1:0] fill_color = '0;
  logic          fill_busy;
  logic          fill_done;
  logic          wr_drop;
  logic [15:0]   stall_count;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  bit acc     = 1'b0;

  always #5 clk = ~clk;

  fb_access_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .fill_start(fill_start), .fill_color(fill_color), .fill_busy(fill_busy),
    .fill_done(fill_done), .wr_drop(wr_drop), .stall_count(stall_count),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port RAM, read-before-write, 1-cycle read latency.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we && int'(mem_addr) < DEPTH) ram[mem_addr] <= mem_wdata;
    if (int'(mem_addr) < DEPTH) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  bit            m_fill_active, m_done_pend, m_drop_pend, m_rd_valid, m_rd_known;
  int            m_fill_pos, m_stall;
  logic [DW-1:0] m_color, m_rd_data;

  function automatic bit exp_busy();
    return m_fill_active || m_done_pend;
  endfunction

  function automatic bit exp_ready();
    return !disp_req && !exp_busy();
  endfunction

  function automatic void exp_mux(output logic we, output logic [AW-1:0] a, output logic [DW-1:0] d);
    we = 1'b0; a = '0; d = '0;
    if (disp_req) a = disp_addr;
    else if (m_fill_active) begin we = 1'b1; a = AW'(m_fill_pos); d = m_color; end
    else if (wr_valid && exp_ready() && int'(wr_addr) < DEPTH) begin
      we = 1'b1; a = wr_addr; d = wr_data;
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_fill_active <= 1'b0; m_done_pend <= 1'b0; m_drop_pend <= 1'b0;
      m_rd_valid <= 1'b0; m_fill_pos <= 0; m_color <= '0; m_stall <= 0;
    end else begin
      m_rd_valid <= disp_req;
      if (disp_req) begin
        m_rd_data  <= m_mem[disp_addr];
        m_rd_known <= m_known[disp_addr];
      end
      if (m_done_pend) m_done_pend <= 1'b0;
      if (m_fill_active && !disp_req) begin
        m_mem[m_fill_pos]   <= m_color;
        m_known[m_fill_pos] <= 1'b1;
        if (m_fill_pos == DEPTH - 1) begin
          m_fill_active <= 1'b0;
          m_done_pend   <= 1'b1;
        end else m_fill_pos <= m_fill_pos + 1;
      end
      if (!exp_busy() && fill_start) begin
        m_fill_active <= 1'b1; m_fill_pos <= 0; m_color <= fill_color;
      end
      if (wr_valid && exp_ready() && int'(wr_addr) < DEPTH) begin
        m_mem[wr_addr]   <= wr_data;
        m_known[wr_addr] <= 1'b1;
      end
      m_drop_pend <= wr_valid && exp_ready() && int'(wr_addr) >= DEPTH;
      if (m_done_pend) m_stall <= 0;
      else if (wr_valid && !exp_ready() && m_stall < 65535) m_stall <= m_stall + 1;
    end
  end

  function automatic int exp_stall();
`ifdef FB_ARB_STATS_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  task automatic compare_cycle();
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    exp_mux(we, a, d);
    check("wr_ready",    32'(wr_ready),    32'(exp_ready()));
    check("mem_we",      32'(mem_we),      32'(we));
    check("mem_addr",    32'(mem_addr),    32'(a));
    if (we) check("mem_wdata", 32'(mem_wdata), 32'(d));
    check("fill_busy",   32'(fill_busy),   32'(exp_busy()));
    check("fill_done",   32'(fill_done),   32'(m_done_pend));
    check("wr_drop",     32'(wr_drop),     32'(m_drop_pend));
    check("stall_count", 32'(stall_count), 32'(exp_stall()));
    if (m_rd_valid && m_rd_known) check("disp_rdata", 32'(disp_rdata), 32'(m_rd_data));
  endtask

  always @(negedge clk) if (reset_n && chk_en) compare_cycle();

  int n_fill_wr = 0;
  int n_done    = 0;
  always @(negedge clk) if (reset_n) begin
    if (mem_we && fill_busy) n_fill_wr <= n_fill_wr + 1;
    if (fill_done)           n_done    <= n_done + 1;
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // One cycle of random traffic; the writer holds each request until accepted.
  task automatic traffic_cycle(input int disp_pct, output bit done_seen);
    @(negedge clk);
    acc       = wr_valid && wr_ready;
    done_seen = fill_done;
    next_cycle();
    if (acc || !wr_valid) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = ($urandom_range(0, 15) == 0) ? AW'(DEPTH + $urandom_range(0, 50))
                                              : AW'($urandom_range(0, DEPTH - 1));
      wr_data  = DW'($urandom);
    end
    disp_req  = ($urandom_range(0, 99) < disp_pct);
    disp_addr = AW'($urandom_range(0, DEPTH - 1));
  endtask

  initial begin
    bit done_seen;
    int fill_wr0, done0, budget;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;

    // Reset state, no requests.
    @(negedge clk);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_fill_busy", 32'(fill_busy), 32'd0);
    check("rst_stall", 32'(stall_count), 32'd0);

    // Writer held off by the display for 10 cycles.
    next_cycle();
    disp_req = 1'b1; disp_addr = '0;
    wr_valid = 1'b1; wr_addr = AW'(500); wr_data = 12'hABC;
    @(negedge clk);
    check("disp_blocks_wr", 32'(wr_ready), 32'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
`ifdef FB_ARB_STATS_EN
    check("stall_10", 32'(stall_count), 32'd10);
`else
    check("stall_tied", 32'(stall_count), 32'd0);
`endif
    next_cycle();
    disp_req = 1'b0;
    @(negedge clk);
    check("held_wr_we", 32'(mem_we), 32'd1);
    check("held_wr_addr", 32'(mem_addr), 32'd500);

    // Display read of address 500.
    next_cycle();
    wr_valid = 1'b0; disp_req = 1'b1; disp_addr = AW'(500);
    @(negedge clk);
    check("disp_mem_addr", 32'(mem_addr), 32'd500);
    check("disp_mem_we", 32'(mem_we), 32'd0);
    next_cycle();
    disp_req = 1'b0;
    @(negedge clk);
    check("disp_rdata_abc", 32'(disp_rdata), 32'hABC);

    // Plain write, then an out-of-range write.
    next_cycle();
    wr_valid = 1'b1; wr_addr = AW'(1234); wr_data = 12'h0F0;
    @(negedge clk);
    check("wr_ready_1234", 32'(wr_ready), 32'd1);
    check("wr_we_1234", 32'(mem_we), 32'd1);
    check("wr_addr_1234", 32'(mem_addr), 32'd1234);
    check("wr_data_1234", 32'(mem_wdata), 32'h0F0);
    next_cycle();
    wr_addr = AW'(DEPTH); wr_data = 12'h123;
    @(negedge clk);
    check("oor_ready", 32'(wr_ready), 32'd1);
    check("oor_we", 32'(mem_we), 32'd0);
    next_cycle();
    wr_valid = 1'b0;
    @(negedge clk);
    check("oor_drop", 32'(wr_drop), 32'd1);

    for (int i = 0; i < 400; i++) traffic_cycle(30, done_seen);

    // Fill coincident with a write: the write lands first, the fill overwrites it.
    @(negedge clk);
    next_cycle();
    disp_req = 1'b0; wr_valid = 1'b1; wr_addr = AW'(7); wr_data = 12'hFFF;
    fill_start = 1'b1; fill_color = 12'h000;
    @(negedge clk);
    check("coinc_ready", 32'(wr_ready), 32'd1);
    check("coinc_addr", 32'(mem_addr), 32'd7);
    fill_wr0 = n_fill_wr; done0 = n_done;
    next_cycle();
    fill_start = 1'b0; wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) traffic_cycle(50, done_seen);
    next_cycle();
    fill_start = 1'b1; fill_color = 12'hFFF;    // ignored mid-fill
    next_cycle();
    fill_start = 1'b0;
    done_seen = 1'b0;
    budget = 0;
    while (!done_seen && budget < 95000) begin
      traffic_cycle((budget < 2000) ? 50 : 6, done_seen);
      budget++;
    end
    check("fill_timeout", 32'(done_seen), 32'd1);
    wr_valid = 1'b0; disp_req = 1'b0;
    @(negedge clk);
    check("fill_write_count", 32'(n_fill_wr - fill_wr0), 32'd76800);
    check("fill_done_pulses", 32'(n_done - done0), 32'd1);
    check("ram_first", 32'(ram[0]), 32'h000);
    check("ram_coinc", 32'(ram[7]), 32'h000);
    check("ram_last", 32'(ram[DEPTH-1]), 32'h000);

    for (int i = 0; i < 200; i++) traffic_cycle(50, done_seen);

    // Reset in the middle of a fill.
    @(negedge clk);
    next_cycle();
    disp_req = 1'b0; wr_valid = 1'b0; fill_start = 1'b1; fill_color = 12'h5A5;
    next_cycle();
    fill_start = 1'b0;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!(mem_we && int'(mem_addr) == 1000) && budget < 5000);
    check("reach_1000", 32'(mem_addr), 32'd1000);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(fill_busy), 32'd0);
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_stall", 32'(stall_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    next_cycle();
    fill_start = 1'b1; fill_color = 12'h123;
    next_cycle();
    fill_start = 1'b0;
    @(negedge clk);
    check("refill_addr0", 32'(mem_addr), 32'd0);
    check("refill_we", 32'(mem_we), 32'd1);
    check("refill_data", 32'(mem_wdata), 32'h123);
    repeat (20) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
